gba_bus_arbiter: RTL and testbench

- Two-master arbiter directly upstream of the memory system's CPU/DMA bus port.
- Selects the CPU or the DMA engine as bus owner and drives the single address/wdata/size/write bus into memory.
- Propagates memory pause back to the owning master and stalls the non-owner.
- Routes read data back to the master that issued the read, accounting for the one-cycle BRAM read latency and the one-cycle write latency.

---
 rtl/gba_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_gba_bus_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gba_bus_arbiter.sv
// ============================================================================
// Module   : gba_bus_arbiter
// Purpose  : Two-master (CPU / DMA) arbiter in front of the memory system's
//            CPU/DMA port. Selects the bus owner, drives the single memory
//            bus, returns pause to the owner while stalling the non-owner,
//            and steers one-cycle-latency read data back to the master that
//            issued the read.
// Ports    : clock, reset (async, active-low)
//            cpu_addr/wdata/size/write  -> CPU request side
//            cpu_rdata, cpu_pause       <- CPU return side
//            dma_req/addr/wdata/size/write -> DMA request side
//            dma_grant, dma_rdata, dma_pause <- DMA return side
//            bus_addr/wdata/size/write  -> memory
//            bus_rdata, bus_pause       <- memory
// Options  : `define ARB_BURST_LIMIT_EN to cap a DMA burst at MAX_BURST
//            unpaused cycles, after which the CPU gets one bus slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gba_bus_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        cpu_pause,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_size,
    input  logic        dma_write,
    output logic        dma_grant,
    output logic [31:0] dma_rdata,
    output logic        dma_pause,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_size,
    output logic        bus_write,
    input  logic [31:0] bus_rdata,
    input  logic        bus_pause
);

    typedef enum logic [1:0] {
        ST_CPU    = 2'd0,
        ST_TO_DMA = 2'd1,
        ST_DMA    = 2'd2,
        ST_TO_CPU = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_rd_dma;      // read data currently in flight belongs to DMA
    logic [31:0] r_hold_addr;
    logic [31:0] r_hold_wdata;
    logic [1:0]  r_hold_size;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_dma_rdata;
    logic        w_limit_hit;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [1:0]  w_size;
    logic        w_write;
    logic [31:0] w_cpu_rdata;
    logic [31:0] w_dma_rdata;

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] r_burst_cnt;

    // Only unpaused DMA cycles count as transferred beats.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_burst_cnt <= '0;
        end else if (r_state != ST_DMA) begin
            r_burst_cnt <= '0;
        end else if (!bus_pause) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    // The beat completing this cycle is the last one allowed in the burst.
    assign w_limit_hit = (r_state == ST_DMA) && !bus_pause && (r_burst_cnt == C_LAST_BEAT);
`else
    // No burst cap: DMA keeps the bus until it drops dma_req. The parameter
    // terms are constant-false for any usable configuration.
    assign w_limit_hit = (MAX_BURST == 0) && (CNT_W == 0);
`endif

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_CPU;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Leaving an owner state waits for bus_pause low so a latched write of
    // the outgoing owner completes before the handoff cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_CPU:    if (dma_req && !bus_pause) w_next_state = ST_TO_DMA;
            ST_TO_DMA: w_next_state = ST_DMA;
            ST_DMA:    if ((!dma_req && !bus_pause) || w_limit_hit) w_next_state = ST_TO_CPU;
            ST_TO_CPU: w_next_state = ST_CPU;
            default:   w_next_state = ST_CPU;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus mux: handoff cycles re-drive the previous owner's request with
    // the write strobe suppressed.
    // ------------------------------------------------------------------
    always_comb begin
        w_addr  = r_hold_addr;
        w_wdata = r_hold_wdata;
        w_size  = r_hold_size;
        w_write = 1'b0;
        case (r_state)
            ST_CPU: begin
                w_addr  = cpu_addr;
                w_wdata = cpu_wdata;
                w_size  = cpu_size;
                w_write = cpu_write;
            end
            ST_DMA: begin
                w_addr  = dma_addr;
                w_wdata = dma_wdata;
                w_size  = dma_size;
                w_write = dma_write;
            end
            default: ;
        endcase
    end

    // Read data arriving this cycle answers the address of the previous
    // cycle, so it follows the registered read owner.
    assign w_cpu_rdata = r_rd_dma ? r_cpu_rdata : bus_rdata;
    assign w_dma_rdata = r_rd_dma ? bus_rdata   : r_dma_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_dma     <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
            r_hold_size  <= '0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
        end else begin
            if (r_state == ST_CPU) begin
                r_rd_dma <= 1'b0;
            end else if (r_state == ST_DMA) begin
                r_rd_dma <= 1'b1;
            end
            r_hold_addr  <= w_addr;
            r_hold_wdata <= w_wdata;
            r_hold_size  <= w_size;
            r_cpu_rdata  <= w_cpu_rdata;
            r_dma_rdata  <= w_dma_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs are forced to zero while reset is asserted so no write can
    // reach memory after reset assertion, even before the next edge.
    // ------------------------------------------------------------------
    assign bus_addr  = reset ? w_addr  : '0;
    assign bus_wdata = reset ? w_wdata : '0;
    assign bus_size  = reset ? w_size  : '0;
    assign bus_write = reset & w_write;
    assign cpu_rdata = reset ? w_cpu_rdata : '0;
    assign dma_rdata = reset ? w_dma_rdata : '0;
    assign cpu_pause = reset & ((r_state != ST_CPU) | bus_pause);
    assign dma_pause = reset & ((r_state != ST_DMA) | bus_pause);
    assign dma_grant = reset & (r_state == ST_DMA);

endmodule

`default_nettype wire

// File: tb/tb_gba_bus_arbiter.sv
`default_nettype none

module tb_gba_bus_arbiter;

`ifdef ARB_BURST_LIMIT_EN
    localparam int TB_MAX_BURST = 4;
`else
    localparam int TB_MAX_BURST = 16;
`endif
    localparam logic [31:0] K = 32'h5A5A_0000;   // wdata = addr ^ K
    localparam int NV = 23;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [1:0]  cpu_size = 2'd2;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_pause;
    logic        dma_req = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [1:0]  dma_size = 2'd1;
    logic        dma_write = 1'b0;
    logic        dma_grant;
    logic [31:0] dma_rdata;
    logic        dma_pause;
    logic [31:0] bus_addr, bus_wdata;
    logic [1:0]  bus_size;
    logic        bus_write;
    logic [31:0] bus_rdata = '0;
    logic        bus_pause = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    gba_bus_arbiter #(.MAX_BURST(TB_MAX_BURST), .CNT_W(5)) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
        .cpu_write(cpu_write), .cpu_rdata(cpu_rdata), .cpu_pause(cpu_pause),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_size(dma_size), .dma_write(dma_write), .dma_grant(dma_grant),
        .dma_rdata(dma_rdata), .dma_pause(dma_pause),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_size(bus_size),
        .bus_write(bus_write), .bus_rdata(bus_rdata), .bus_pause(bus_pause)
    );

    typedef struct {
        logic        req, cw, dw;
        logic [31:0] ca, da;
        logic        bp;
        logic [31:0] rd;
        logic        g, cp, dp, bw;
        logic [31:0] ba, crd, drd;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic req, input logic cw, input logic dw,
                                input logic [31:0] ca, input logic [31:0] da,
                                input logic bp, input logic [31:0] rd,
                                input logic g, input logic cp, input logic dp,
                                input logic bw, input logic [31:0] ba,
                                input logic [31:0] crd, input logic [31:0] drd);
        vec_t v;
        v.req = req; v.cw = cw; v.dw = dw; v.ca = ca; v.da = da; v.bp = bp; v.rd = rd;
        v.g = g; v.cp = cp; v.dp = dp; v.bw = bw; v.ba = ba; v.crd = crd; v.drd = drd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic cw, input logic dw,
                         input logic [31:0] ca, input logic [31:0] da,
                         input logic bp, input logic [31:0] rd);
        dma_req   = req;
        cpu_write = cw;
        dma_write = dw;
        cpu_addr  = ca;
        cpu_wdata = ca ^ K;
        dma_addr  = da;
        dma_wdata = da ^ K;
        bus_pause = bp;
        bus_rdata = rd;
    endtask

    initial begin
        //               req cw dw ca            da            bp rd            g  cp dp bw ba            crd           drd
        vecs[0]  = mk(0, 0, 0, 32'h03000010, 32'h06000000, 0, 32'h11111111, 0, 0, 1, 0, 32'h03000010, 32'h11111111, 32'h0);
        vecs[1]  = mk(0, 0, 0, 32'h03000020, 32'h06000000, 0, 32'hCAFEF00D, 0, 0, 1, 0, 32'h03000020, 32'hCAFEF00D, 32'h0);
        vecs[2]  = mk(0, 1, 0, 32'h02000000, 32'h06000000, 0, 32'h0,        0, 0, 1, 1, 32'h02000000, 32'h0,        32'h0);
        vecs[3]  = mk(1, 0, 0, 32'h02000004, 32'h06000000, 1, 32'h0,        0, 1, 1, 0, 32'h02000004, 32'h0,        32'h0);
        vecs[4]  = mk(1, 0, 0, 32'h03000000, 32'h06000000, 0, 32'h0,        0, 0, 1, 0, 32'h03000000, 32'h0,        32'h0);
        vecs[5]  = mk(1, 1, 1, 32'h02000008, 32'h06000000, 0, 32'hDEADBEEF, 0, 1, 1, 0, 32'h03000000, 32'hDEADBEEF, 32'h0);
        vecs[6]  = mk(1, 0, 1, 32'h0,        32'h06000000, 0, 32'h12345678, 1, 1, 0, 1, 32'h06000000, 32'h12345678, 32'h0);
        vecs[7]  = mk(1, 0, 1, 32'h0,        32'h06000004, 1, 32'h0,        1, 1, 1, 1, 32'h06000004, 32'h12345678, 32'h0);
        vecs[8]  = mk(1, 0, 1, 32'h0,        32'h06000004, 0, 32'h0,        1, 1, 0, 1, 32'h06000004, 32'h12345678, 32'h0);
        vecs[9]  = mk(1, 0, 1, 32'h0,        32'h06000008, 1, 32'h0,        1, 1, 1, 1, 32'h06000008, 32'h12345678, 32'h0);
        vecs[10] = mk(1, 0, 1, 32'h0,        32'h06000008, 0, 32'h0,        1, 1, 0, 1, 32'h06000008, 32'h12345678, 32'h0);
        vecs[11] = mk(1, 0, 1, 32'h0,        32'h0600000C, 1, 32'h0,        1, 1, 1, 1, 32'h0600000C, 32'h12345678, 32'h0);
        vecs[12] = mk(1, 0, 1, 32'h0,        32'h0600000C, 0, 32'h0,        1, 1, 0, 1, 32'h0600000C, 32'h12345678, 32'h0);
        vecs[13] = mk(1, 0, 0, 32'h0,        32'h06000100, 1, 32'h0,        1, 1, 1, 0, 32'h06000100, 32'h12345678, 32'h0);
        vecs[14] = mk(0, 0, 0, 32'h0,        32'h06000100, 0, 32'hABCD0001, 1, 1, 0, 0, 32'h06000100, 32'h12345678, 32'hABCD0001);
        vecs[15] = mk(0, 1, 0, 32'h02000010, 32'h0,        0, 32'hABCD0002, 0, 1, 1, 0, 32'h06000100, 32'h12345678, 32'hABCD0002);
        vecs[16] = mk(0, 1, 0, 32'h02000010, 32'h0,        0, 32'h55555555, 0, 0, 1, 1, 32'h02000010, 32'h12345678, 32'h55555555);
        vecs[17] = mk(0, 0, 0, 32'h03000000, 32'h0,        1, 32'h0,        0, 1, 1, 0, 32'h03000000, 32'h0,        32'h55555555);
        vecs[18] = mk(1, 1, 0, 32'h02000020, 32'h0,        0, 32'h77777777, 0, 0, 1, 1, 32'h02000020, 32'h77777777, 32'h55555555);
        vecs[19] = mk(0, 1, 0, 32'h02000024, 32'h0,        1, 32'h0,        0, 1, 1, 0, 32'h02000020, 32'h0,        32'h55555555);
        vecs[20] = mk(0, 0, 0, 32'h0,        32'h06000200, 0, 32'h0,        1, 1, 0, 0, 32'h06000200, 32'h0,        32'h55555555);
        vecs[21] = mk(0, 0, 0, 32'h0,        32'h0,        0, 32'h99999999, 0, 1, 1, 0, 32'h06000200, 32'h0,        32'h99999999);
        vecs[22] = mk(0, 0, 0, 32'h03000040, 32'h0,        0, 32'h0,        0, 0, 1, 0, 32'h03000040, 32'h0,        32'h0);

        // ---------------- reset with random activity on inputs ----------------
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            drive(1'($urandom), 1'b1, 1'b1, $urandom, $urandom, 1'b1, $urandom);
        end
        #2;
        check("rst_grant", 32'(dma_grant), 32'h0);
        check("rst_cpu_pause", 32'(cpu_pause), 32'h0);
        check("rst_dma_pause", 32'(dma_pause), 32'h0);
        check("rst_bus_write", 32'(bus_write), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_size", 32'(bus_size), 32'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_dma_rdata", dma_rdata, 32'h0);

`ifdef ARB_BURST_LIMIT_EN
        // ---------------- burst cap: 4 on, 3 off with DMA always requesting ----------------
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b1, 32'h03000000, 32'h06000000, 1'b0, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 21; i++) begin
            logic eg, ecp;
            if (i > 0) @(negedge clock);
            #2;
            eg  = (i >= 2) && (((i - 2) % 7) < 4);
            ecp = !((i % 7) == 0);
            check($sformatf("burst%0d_grant", i), 32'(dma_grant), 32'(eg));
            check($sformatf("burst%0d_cpu_pause", i), 32'(cpu_pause), 32'(ecp));
        end
`else
        // ---------------- table-driven main sequence ----------------
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h03000000, 32'h06000000, 1'b0, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(vecs[i].req, vecs[i].cw, vecs[i].dw, vecs[i].ca, vecs[i].da, vecs[i].bp, vecs[i].rd);
            #2;
            check($sformatf("r%0d_grant", i), 32'(dma_grant), 32'(vecs[i].g));
            check($sformatf("r%0d_cpu_pause", i), 32'(cpu_pause), 32'(vecs[i].cp));
            check($sformatf("r%0d_dma_pause", i), 32'(dma_pause), 32'(vecs[i].dp));
            check($sformatf("r%0d_bus_write", i), 32'(bus_write), 32'(vecs[i].bw));
            check($sformatf("r%0d_bus_addr", i), bus_addr, vecs[i].ba);
            check($sformatf("r%0d_bus_wdata", i), bus_wdata, vecs[i].ba ^ K);
            check($sformatf("r%0d_cpu_rdata", i), cpu_rdata, vecs[i].crd);
            check($sformatf("r%0d_dma_rdata", i), dma_rdata, vecs[i].drd);
        end
`endif

        // ---------------- asynchronous reset in the middle of a DMA burst ----------------
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b1, 32'h03000000, 32'h06000300, 1'b0, 32'h0);
        repeat (2) @(negedge clock);
        #2;
        check("mid_grant_before", 32'(dma_grant), 32'h1);
        check("mid_write_before", 32'(bus_write), 32'h1);
        check("mid_size_before", 32'(bus_size), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("mid_grant_rst", 32'(dma_grant), 32'h0);
        check("mid_write_rst", 32'(bus_write), 32'h0);
        check("mid_addr_rst", bus_addr, 32'h0);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h03000080, 32'h06000300, 1'b0, 32'h0);
        reset = 1'b1;
        #2;
        check("post_rst_grant", 32'(dma_grant), 32'h0);
        check("post_rst_cpu_pause", 32'(cpu_pause), 32'h0);
        check("post_rst_bus_addr", bus_addr, 32'h03000080);
        check("post_rst_bus_size", 32'(bus_size), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
